// File: rtl/engine_seq_ctrl_if.sv
// Operand/result bus between the fetch logic (master) and the engine sequencer (slave).
interface engine_seq_ctrl_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 4,
  parameter int RESULT_WIDTH = 16,
  parameter int NUM_PE       = 4,
  parameter int DATA_NUM     = 4,
  parameter int CNT_WIDTH    = 8
);
  logic                                     start;
  logic [CNT_WIDTH-1:0]                     k_tiles;
  logic                                     busy;
  logic                                     in_valid;
  logic                                     in_ready;
  logic [NUM_PE*DATA_NUM*DATA_WIDTH-1:0]    in_data;
  logic [DATA_NUM*WEIGHT_WIDTH-1:0]         in_weight;
  logic [NUM_PE*DATA_NUM*DATA_WIDTH-1:0]    eng_data;
  logic [DATA_NUM*WEIGHT_WIDTH-1:0]         eng_weight;
  logic [NUM_PE*RESULT_WIDTH-1:0]           eng_result;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [NUM_PE*RESULT_WIDTH-1:0]           out_result;

  modport master (
    output start, k_tiles, in_valid, in_data, in_weight, eng_result, out_ready,
    input  busy, in_ready, eng_data, eng_weight, out_valid, out_result
  );

  modport slave (
    input  start, k_tiles, in_valid, in_data, in_weight, eng_result, out_ready,
    output busy, in_ready, eng_data, eng_weight, out_valid, out_result
  );
endinterface

// File: rtl/engine_seq_ctrl.sv
// Job sequencer for the 4-PE dot-product engine: streams K beats onto the
// engine operand bus and accumulates each PE's result across the job.

module engine_seq_acc #(
  parameter int RESULT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [RESULT_WIDTH-1:0] res,
  output logic [RESULT_WIDTH-1:0] acc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + res;
  end
endmodule

module engine_seq_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 4,
  parameter int RESULT_WIDTH = 16,
  parameter int NUM_PE       = 4,
  parameter int DATA_NUM     = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic              clk,
  input  logic              rst,
  engine_seq_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                                state;
  logic [CNT_WIDTH-1:0]                  k_lat;
  logic [CNT_WIDTH-1:0]                  cnt;
  logic                                  pend;
  logic                                  accept;
  logic                                  clr;
  logic                                  last_acc;
  logic [NUM_PE*DATA_NUM*DATA_WIDTH-1:0] data_q;
  logic [DATA_NUM*WEIGHT_WIDTH-1:0]      wt_q;
  logic [NUM_PE-1:0][RESULT_WIDTH-1:0]   res_v;
  logic [NUM_PE-1:0][RESULT_WIDTH-1:0]   acc_v;

  assign bus.in_ready   = (state == RUN) && (cnt < k_lat);
  assign accept         = bus.in_valid && bus.in_ready;
  assign clr            = (state == IDLE) && bus.start;
  // cnt already counts the beat whose result is being folded in this cycle
  assign last_acc       = pend && (cnt == k_lat);
  assign res_v          = bus.eng_result;
  assign bus.out_result = acc_v;
  assign bus.eng_data   = data_q;
  assign bus.eng_weight = wt_q;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
    engine_seq_acc #(.RESULT_WIDTH(RESULT_WIDTH)) u_acc (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (pend),
      .res (res_v[g]),
      .acc (acc_v[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      k_lat         <= '0;
      cnt           <= '0;
      pend          <= 1'b0;
      data_q        <= '0;
      wt_q          <= '0;
    end else begin
      pend <= accept;
      if (accept) begin
        data_q <= bus.in_data;
        wt_q   <= bus.in_weight;
        cnt    <= cnt + 1'b1;
      end
      case (state)
        IDLE: if (bus.start) begin
          cnt      <= '0;
          k_lat    <= bus.k_tiles;
          bus.busy <= 1'b1;
          if (bus.k_tiles == '0) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: if (last_acc) begin
          state         <= DONE;
          bus.out_valid <= 1'b1;
        end
        DONE: if (bus.out_valid && bus.out_ready) begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
